stack_addr_sched: RTL and testbench
===================================

STACK_ADDR_SCHED -- requirements
Module: stack_addr_sched

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 16, datapath word width; DEPTH, 3, address-stack entries.
REQ-002 Ports SHALL be:
- clk  in  1  single clock.
- rst  in  1  reset; asynchronous, active-high.
- req0_vld / req1_vld  in  1  request valid, requester 0 / 1.
- req0_op / req1_op  in  2  op code: 00 POP, 01 PUSH1, 11 PUSH2, 10 reserved (treated as PUSH1).
- req0_data / req1_data  in  DATA_WIDTH  push payload.
- req0_rdy / req1_rdy  out  1  request accepted this cycle.
- stk_ctl  out  2  command to stack datapath.
- stk_vld  out  1  stk_ctl/stk_data valid this cycle.
- stk_data  out  DATA_WIDTH  payload to stack datapath.
- stk_dout  in  DATA_WIDTH  stack datapath output.
- rsp_vld  out  1  pop result valid.
- rsp_id  out  1  requester owning rsp_data.
- rsp_data  out  DATA_WIDTH  popped address.
- occ  out  2  current stack occupancy, 0..DEPTH.
- err_ovf / err_udf  out  1  one-cycle overflow / underflow pulse.

Function
REQ-003 Handshake SHALL be: a request is accepted when reqN_vld and reqN_rdy are both 1 on a rising clk edge. At most one rdy SHALL be 1 per cycle.
REQ-004 FSM SHALL have states IDLE, ISSUE, RESP. IDLE -> ISSUE on acceptance. ISSUE -> RESP for POP. ISSUE -> IDLE for push. RESP -> IDLE unconditionally.
REQ-005 rdy SHALL be asserted only in IDLE, combinationally, toward the arbitration winner.
REQ-006 Arbitration SHALL be round-robin: after an acceptance from requester N, requester 1-N wins the next tie. Reset SHALL favour requester 0.
REQ-007 In ISSUE, stk_vld SHALL be 1 for exactly one cycle, with stk_ctl = the accepted op and stk_data = the captured payload.
REQ-008 Reserved op 10 SHALL be issued as stk_ctl 01.
REQ-009 A pop result SHALL be taken in RESP: rsp_vld = 1 for one cycle, rsp_data = stk_dout, rsp_id = the accepted requester. Pop latency from acceptance to rsp_vld SHALL be 2 cycles.
REQ-010 occ SHALL update in ISSUE: POP -1, PUSH1 +1, PUSH2 +2. The update is an unsigned 2-bit value, saturating to 0..DEPTH.
REQ-011 Overflow SHALL be detected at acceptance when occ + push count > DEPTH. The request is then accepted but not issued; err_ovf pulses in the next cycle; occ is unchanged; FSM returns to IDLE.
REQ-012 Underflow SHALL be detected at acceptance as POP with occ = 0. It is handled the same way with err_udf; no rsp_vld.
REQ-013 With stk_vld = 0, stk_ctl SHALL be 00 and stk_data SHALL be 0.
REQ-014 The scheduler SHALL sustain one push per 2 cycles and one pop per 3 cycles. Requests arriving outside IDLE SHALL wait; no request is lost while reqN_vld is held.

Reset
REQ-015 On rst = 1, asynchronously: FSM = IDLE, occ = 0, round-robin pointer = requester 0.
REQ-016 On rst = 1, asynchronously, all outputs SHALL be 0 (rdy, stk_vld, stk_ctl, stk_data, rsp_*, err_*).
REQ-017 Reset mid-operation SHALL abort any in-flight command with no rsp_vld or err pulse. Operation SHALL resume on the first clk edge after deassertion.

Configuration
REQ-018 With macro STACK_SCHED_PRIO_EN defined, arbitration SHALL be fixed priority, requester 0 over requester 1.
REQ-019 Without STACK_SCHED_PRIO_EN, arbitration SHALL be round-robin per REQ-006.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Scenario A: after reset, req0 PUSH1 data 0x1234 -> stk_vld 1 cycle with stk_ctl 01, stk_data 0x1234; then occ = 1.
- Scenario B: occ = 1, req1 POP, stk_dout = 0x5034 -> rsp_vld 2 cycles after accept, rsp_id 1, rsp_data 0x5034, occ = 0.
- Scenario C: occ = 2, req0 PUSH2 -> no stk_vld, err_ovf 1-cycle pulse, occ stays 2.
- Scenario D: occ = 0, POP -> err_udf pulse, no rsp_vld, occ stays 0.
- Scenario E: req0 and req1 both holding PUSH1, 4 accepts -> grant order 0, 1, 0, 1 (0, 0, ... with STACK_SCHED_PRIO_EN); overflow on 4th.
- Scenario F: rst asserted during RESP -> outputs 0 immediately, no rsp_vld, occ = 0.

Source files
------------

// File: rtl/stack_addr_sched.sv
// Two-requester scheduler in front of an address-stack datapath: arbitrates,
// issues one stack command per request, returns pop results, and tracks occupancy.
// Define STACK_SCHED_PRIO_EN for fixed priority (req0 over req1); default is round-robin.
module stack_addr_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_vld,
  input  logic [1:0]            req0_op,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_rdy,
  input  logic                  req1_vld,
  input  logic [1:0]            req1_op,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_rdy,
  output logic [1:0]            stk_ctl,
  output logic                  stk_vld,
  output logic [DATA_WIDTH-1:0] stk_data,
  input  logic [DATA_WIDTH-1:0] stk_dout,
  output logic                  rsp_vld,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [1:0]            occ,
  output logic                  err_ovf,
  output logic                  err_udf
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam logic [1:0] OP_POP   = 2'b00;
  localparam logic [1:0] OP_PUSH1 = 2'b01;
  localparam logic [1:0] OP_RSVD  = 2'b10;
  localparam logic [1:0] OP_PUSH2 = 2'b11;

  localparam logic [2:0] DEPTH_W = 3'(DEPTH);

  function automatic logic [1:0] push_cnt(input logic [1:0] op);
    case (op)
      OP_POP:   push_cnt = 2'd0;
      OP_PUSH2: push_cnt = 2'd2;
      default:  push_cnt = 2'd1;
    endcase
  endfunction

  logic [1:0]            r_state;
  logic [1:0]            r_occ;
  logic [1:0]            r_op;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_id;
  logic                  r_ovf;
  logic                  r_udf;

  logic                  w_idle;
  logic                  w_pick1;
  logic                  w_acc;
  logic [1:0]            w_raw_op;
  logic [1:0]            w_sel_op;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [2:0]            w_acc_sum;
  logic                  w_ovf;
  logic                  w_udf;
  logic [2:0]            w_iss_sum;
  logic [1:0]            w_occ_push;
  logic                  w_issue;

`ifdef STACK_SCHED_PRIO_EN
  assign w_pick1 = req1_vld && !req0_vld;
`else
  logic r_rr;

  // r_rr = 1 means requester 1 wins the next tie.
  assign w_pick1 = req1_vld && (!req0_vld || r_rr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr <= 1'b0;
    end else if (w_acc) begin
      r_rr <= ~w_pick1;
    end
  end
`endif

  // rdy is gated by rst so nothing is granted while reset is held.
  assign w_idle   = (r_state == S_IDLE) && !rst;
  assign req0_rdy = w_idle && req0_vld && !w_pick1;
  assign req1_rdy = w_idle && w_pick1;
  assign w_acc    = req0_rdy || req1_rdy;

  assign w_raw_op   = w_pick1 ? req1_op : req0_op;
  assign w_sel_op   = (w_raw_op == OP_RSVD) ? OP_PUSH1 : w_raw_op;
  assign w_sel_data = w_pick1 ? req1_data : req0_data;

  assign w_acc_sum = {1'b0, r_occ} + {1'b0, push_cnt(w_sel_op)};
  assign w_ovf     = (w_sel_op != OP_POP) && (w_acc_sum > DEPTH_W);
  assign w_udf     = (w_sel_op == OP_POP) && (r_occ == 2'd0);

  assign w_iss_sum  = {1'b0, r_occ} + {1'b0, push_cnt(r_op)};
  assign w_occ_push = (w_iss_sum > DEPTH_W) ? DEPTH_W[1:0] : w_iss_sum[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_occ   <= '0;
      r_op    <= '0;
      r_data  <= '0;
      r_id    <= 1'b0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_state <= S_ISSUE;
            r_op    <= w_sel_op;
            r_data  <= w_sel_data;
            r_id    <= w_pick1;
            r_ovf   <= w_ovf;
            r_udf   <= w_udf;
          end
        end
        S_ISSUE: begin
          if (r_ovf || r_udf) begin
            r_state <= S_IDLE;
          end else if (r_op == OP_POP) begin
            r_occ   <= (r_occ == 2'd0) ? 2'd0 : r_occ - 2'd1;
            r_state <= S_RESP;
          end else begin
            r_occ   <= w_occ_push;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_issue  = (r_state == S_ISSUE) && !r_ovf && !r_udf;
  assign stk_vld  = w_issue;
  assign stk_ctl  = w_issue ? r_op : '0;
  assign stk_data = w_issue ? r_data : '0;

  assign err_ovf  = (r_state == S_ISSUE) && r_ovf;
  assign err_udf  = (r_state == S_ISSUE) && r_udf;

  assign rsp_vld  = (r_state == S_RESP);
  assign rsp_id   = (r_state == S_RESP) ? r_id : 1'b0;
  assign rsp_data = (r_state == S_RESP) ? stk_dout : '0;

  assign occ = r_occ;

endmodule

// File: tb/tb_stack_addr_sched.sv
// Directed bench for stack_addr_sched; expected stack commands, pop responses and
// error pulses are queued at acceptance and matched by a negedge monitor.
module tb_stack_addr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_vld, req1_vld;
  logic [1:0]  req0_op, req1_op;
  logic [15:0] req0_data, req1_data;
  logic        req0_rdy, req1_rdy;
  logic [1:0]  stk_ctl;
  logic        stk_vld;
  logic [15:0] stk_data;
  logic [15:0] stk_dout;
  logic        rsp_vld, rsp_id;
  logic [15:0] rsp_data;
  logic [1:0]  occ;
  logic        err_ovf, err_udf;

  stack_addr_sched #(.DATA_WIDTH(16), .DEPTH(3)) dut (
    .clk(clk), .rst(rst),
    .req0_vld(req0_vld), .req0_op(req0_op), .req0_data(req0_data), .req0_rdy(req0_rdy),
    .req1_vld(req1_vld), .req1_op(req1_op), .req1_data(req1_data), .req1_rdy(req1_rdy),
    .stk_ctl(stk_ctl), .stk_vld(stk_vld), .stk_data(stk_data), .stk_dout(stk_dout),
    .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .occ(occ), .err_ovf(err_ovf), .err_udf(err_udf)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int unsigned cyc; logic [1:0] ctl; logic [15:0] data; } stk_exp_t;
  typedef struct { int unsigned cyc; logic id; logic [15:0] data; } rsp_exp_t;
  typedef struct { int unsigned cyc; logic ovf; } err_exp_t;

  stk_exp_t stk_q[$];
  rsp_exp_t rsp_q[$];
  err_exp_t err_q[$];

  int unsigned n_pass = 0, n_fail = 0, n_total = 0;
  int          occ_m = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  stk_exp_t m_s;
  rsp_exp_t m_r;
  err_exp_t m_e;

  always @(negedge clk) begin
    check("rdy_exclusive", 32'(req0_rdy & req1_rdy), 0);
    if (stk_vld) begin
      if (stk_q.size() == 0) check("stk_unexpected", 32'(stk_vld), 0);
      else begin
        m_s = stk_q.pop_front();
        check("stk_cycle", cyc, m_s.cyc);
        check("stk_ctl", 32'(stk_ctl), 32'(m_s.ctl));
        check("stk_data", 32'(stk_data), 32'(m_s.data));
      end
    end else begin
      check("stk_idle_ctl", 32'(stk_ctl), 0);
      check("stk_idle_data", 32'(stk_data), 0);
    end
    if (rsp_vld) begin
      if (rsp_q.size() == 0) check("rsp_unexpected", 32'(rsp_vld), 0);
      else begin
        m_r = rsp_q.pop_front();
        check("rsp_cycle", cyc, m_r.cyc);
        check("rsp_id", 32'(rsp_id), 32'(m_r.id));
        check("rsp_data", 32'(rsp_data), 32'(m_r.data));
      end
    end
    if (err_ovf || err_udf) begin
      if (err_q.size() == 0) check("err_unexpected", 32'(err_ovf | err_udf), 0);
      else begin
        m_e = err_q.pop_front();
        check("err_cycle", cyc, m_e.cyc);
        check("err_ovf", 32'(err_ovf), 32'(m_e.ovf));
        check("err_udf", 32'(err_udf), 32'(!m_e.ovf));
      end
    end
  end

  // Reference behaviour at acceptance: queue what the DUT must emit and update occupancy.
  task automatic push_exp(input logic id, input logic [1:0] op, input logic [15:0] data,
                          input int unsigned acc_cyc, input bit abort_rsp);
    int cnt;
    logic [1:0] ctl;
    ctl = (op == 2'b10) ? 2'b01 : op;
    cnt = (ctl == 2'b00) ? 0 : (ctl == 2'b11) ? 2 : 1;
    if (ctl == 2'b00) begin
      if (occ_m == 0) err_q.push_back('{acc_cyc, 1'b0});
      else begin
        stk_q.push_back('{acc_cyc, 2'b00, data});
        if (!abort_rsp) rsp_q.push_back('{acc_cyc + 1, id, stk_dout});
        occ_m--;
      end
    end else if (occ_m + cnt > 3) begin
      err_q.push_back('{acc_cyc, 1'b1});
    end else begin
      stk_q.push_back('{acc_cyc, ctl, data});
      occ_m += cnt;
    end
  endtask

  task automatic accept(input logic id, input logic [1:0] op, input logic [15:0] data,
                        input bit abort_rsp);
    int t;
    @(negedge clk);
    req0_vld = (id == 1'b0); req0_op = op; req0_data = data;
    req1_vld = (id == 1'b1); req1_op = op; req1_data = data;
    #1;
    t = 0;
    while (!(req0_rdy || req1_rdy) && t < 20) begin
      @(negedge clk); #1; t++;
    end
    check("grant_to_requester", 32'(id ? req1_rdy : req0_rdy), 1);
    push_exp(id, op, data, cyc + 1, abort_rsp);
    @(posedge clk); #1;
    req0_vld = 1'b0; req1_vld = 1'b0;
  endtask

  task automatic do_req(input logic id, input logic [1:0] op, input logic [15:0] data);
    accept(id, op, data, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("occ_after_req", 32'(occ), 32'(occ_m));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rdy0"}, 32'(req0_rdy), 0);
    check({tag, "_rdy1"}, 32'(req1_rdy), 0);
    check({tag, "_stk_vld"}, 32'(stk_vld), 0);
    check({tag, "_stk_ctl"}, 32'(stk_ctl), 0);
    check({tag, "_stk_data"}, 32'(stk_data), 0);
    check({tag, "_rsp_vld"}, 32'(rsp_vld), 0);
    check({tag, "_rsp_id"}, 32'(rsp_id), 0);
    check({tag, "_rsp_data"}, 32'(rsp_data), 0);
    check({tag, "_occ"}, 32'(occ), 0);
    check({tag, "_err_ovf"}, 32'(err_ovf), 0);
    check({tag, "_err_udf"}, 32'(err_udf), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_vld = 1'b1; req1_vld = 1'b1;
    #1;
    check_zero("reset");
    @(negedge clk);
    req0_vld = 1'b0; req1_vld = 1'b0;
    rst = 1'b0;
    occ_m = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc_prev, acc_now;
    int t;
    logic winner, exp_id;
    rst = 1'b1;
    req0_vld = 1'b1; req1_vld = 1'b1;
    req0_op = 2'b01; req1_op = 2'b01;
    req0_data = 16'h0; req1_data = 16'h0;
    stk_dout = 16'h0;
    #2;
    check_zero("por");
    repeat (2) @(negedge clk);
    req0_vld = 1'b0; req1_vld = 1'b0;
    rst = 1'b0;

    // Scenario A / B / D and the reserved opcode
    do_req(1'b0, 2'b01, 16'h1234);
    stk_dout = 16'h5034;
    do_req(1'b1, 2'b00, 16'h0000);
    do_req(1'b0, 2'b00, 16'h0000);
    do_req(1'b1, 2'b10, 16'h0BEE);
    // Scenario C, then fill to DEPTH exactly and overflow by one
    do_req(1'b0, 2'b01, 16'h2345);
    do_req(1'b0, 2'b11, 16'hDEAD);
    stk_dout = 16'h4444;
    do_req(1'b1, 2'b00, 16'h0000);
    do_req(1'b1, 2'b11, 16'h3456);
    do_req(1'b0, 2'b01, 16'hBEEF);

    // Scenario E: both requesters hold PUSH1 for four acceptances
    do_reset();
    @(negedge clk);
    req0_vld = 1'b1; req0_op = 2'b01; req0_data = 16'hA000;
    req1_vld = 1'b1; req1_op = 2'b01; req1_data = 16'hB000;
    acc_prev = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      t = 0;
      while (!(req0_rdy || req1_rdy) && t < 20) begin
        @(negedge clk); #1; t++;
      end
      check("E_grant_seen", 32'(req0_rdy | req1_rdy), 1);
      winner = req1_rdy;
`ifdef STACK_SCHED_PRIO_EN
      exp_id = 1'b0;
`else
      exp_id = (k % 2 == 1);
`endif
      check("E_grant_order", 32'(winner), 32'(exp_id));
      acc_now = cyc + 1;
      if (k > 0) check("E_push_interval", acc_now - acc_prev, 2);
      acc_prev = acc_now;
      push_exp(winner, 2'b01, winner ? 16'hB000 : 16'hA000, acc_now, 1'b0);
      @(posedge clk);
      if (k < 3) @(negedge clk);
    end
    #1;
    req0_vld = 1'b0; req1_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("E_occ", 32'(occ), 3);

    // Scenario F: reset while the pop response is being presented
    do_reset();
    do_req(1'b0, 2'b01, 16'h1111);
    stk_dout = 16'h9999;
    accept(1'b1, 2'b00, 16'h0000, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero("F_midreset");
    occ_m = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_req(1'b1, 2'b01, 16'h2222);

    repeat (3) @(negedge clk);
    check("stk_queue_drained", 32'(stk_q.size()), 0);
    check("rsp_queue_drained", 32'(rsp_q.size()), 0);
    check("err_queue_drained", 32'(err_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
